// File: rtl/fft_frame_scheduler_pkg.sv
// fft_sched_pkg: shared definitions for the FFT frame scheduler.
//   sched_state_t : scheduler FSM state encoding (S_IDLE..S_READOUT)
//   CH_L / CH_R   : channel indices (bit positions in FrameReady/Overrun, ChSel value)
package fft_sched_pkg;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_START     = 3'd1,
    S_WAIT_BUSY = 3'd2,
    S_RUN       = 3'd3,
    S_READOUT   = 3'd4
  } sched_state_t;

  localparam logic CH_L = 1'b0;
  localparam logic CH_R = 1'b1;

endpackage

// File: rtl/fft_frame_scheduler_rr_arb2.sv
// rr_arb2: two-requester round-robin arbiter.
//   Clock, Reset : system clock, asynchronous active-high reset
//   Req[1:0]     : request per channel
//   Update       : grant was taken this cycle; remember it as the last winner
//   Grant        : winning channel index (combinational)
//   Valid        : at least one request present (combinational)
// The last winner resets to CH_R so that the left channel wins the first tie.
module rr_arb2
  import fft_sched_pkg::*;
(
  input  logic       Clock,
  input  logic       Reset,
  input  logic [1:0] Req,
  input  logic       Update,
  output logic       Grant,
  output logic       Valid
);

  logic last_ch;

  always_comb begin
    Valid = |Req;
    if (Req == 2'b11) Grant = ~last_ch;
    else              Grant = Req[1];
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset)       last_ch <= CH_R;
    else if (Update) last_ch <= Grant;
  end

endmodule

// File: rtl/fft_frame_scheduler.sv
// fft_frame_scheduler: shares one FFT core between the left and right channel
// buffers. Latches frame-ready events, arbitrates round-robin, starts the core,
// supervises it with a watchdog and holds the result until it is acknowledged.
//   Clock, Reset : system clock, asynchronous active-high reset
//   Enable       : low blocks new core starts (pending frames still latch)
//   FrameReady   : per-channel frame-complete pulse (bit0 L, bit1 R)
//   CoreStart    : one-cycle start pulse to the FFT core
//   CoreBusy     : core busy level
//   CoreEnd      : core done pulse
//   CoreAbort    : one-cycle abort pulse on timeout
//   ChSel        : channel bank muxed onto the core
//   ResultReq    : spectrum of ChSel is ready for readout
//   ResultAck    : reader done, releases the bank
//   ClrErr       : clears Overrun and Timeout (a simultaneous new error wins)
//   Overrun      : sticky per-channel overrun flags
//   Timeout      : sticky watchdog / busy-wait expiry flag
module fft_frame_scheduler
  import fft_sched_pkg::*;
#(
  parameter int unsigned wdt_limit = 60000,
  parameter int unsigned bw_wdt    = 16,
  parameter int unsigned busy_wait = 4
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       Enable,
  input  logic [1:0] FrameReady,
  output logic       CoreStart,
  input  logic       CoreBusy,
  input  logic       CoreEnd,
  output logic       CoreAbort,
  output logic       ChSel,
  output logic       ResultReq,
  input  logic       ResultAck,
  input  logic       ClrErr,
  output logic [1:0] Overrun,
  output logic       Timeout
);

  localparam logic [bw_wdt-1:0] WDT_LAST  = bw_wdt'(wdt_limit - 1);
  localparam logic [bw_wdt-1:0] BUSY_LAST = bw_wdt'(busy_wait - 1);

  sched_state_t      state, state_n;
  logic [1:0]        pending;
  logic [bw_wdt-1:0] cnt;

  logic       grant;
  logic       req_valid;
  logic       grant_en;
  logic       cnt_clr;
  logic       cnt_inc;
  logic       to_evt;
  logic [1:0] clr_mask;
  logic [1:0] ov_set;

  rr_arb2 u_arb (
    .Clock  (Clock),
    .Reset  (Reset),
    .Req    (pending),
    .Update (grant_en),
    .Grant  (grant),
    .Valid  (req_valid)
  );

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) state <= S_IDLE;
    else       state <= state_n;
  end

  // Counter is shared: busy-wait timer in WAIT_BUSY, watchdog in RUN.
  // Its last value is compared so that "reaching the limit" and the state
  // transition land on the same edge.
  always_comb begin
    state_n  = state;
    grant_en = 1'b0;
    cnt_clr  = 1'b0;
    cnt_inc  = 1'b0;
    to_evt   = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (Enable && req_valid) begin
          grant_en = 1'b1;
          state_n  = S_START;
        end
      end
      S_START: begin
        cnt_clr = 1'b1;
        state_n = S_WAIT_BUSY;
      end
      S_WAIT_BUSY: begin
        if (CoreBusy) begin
          cnt_clr = 1'b1;
          state_n = S_RUN;
        end else if (cnt == BUSY_LAST) begin
          to_evt  = 1'b1;
          state_n = S_IDLE;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      S_RUN: begin
        if (CoreEnd) begin
          state_n = S_READOUT;
        end else if (cnt == WDT_LAST) begin
          to_evt  = 1'b1;
          state_n = S_IDLE;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      S_READOUT: begin
        if (ResultAck) state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_comb begin
    clr_mask = '0;
    if (grant_en) clr_mask[grant] = 1'b1;
    // A frame arriving on the granting edge is a fresh frame, not an overrun.
    ov_set = FrameReady & pending & ~clr_mask;
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset)        cnt <= '0;
    else if (cnt_clr) cnt <= '0;
    else if (cnt_inc) cnt <= cnt + 1'b1;
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      pending   <= '0;
      Overrun   <= '0;
      Timeout   <= 1'b0;
      CoreStart <= 1'b0;
      CoreAbort <= 1'b0;
      ResultReq <= 1'b0;
      ChSel     <= CH_L;
    end else begin
      pending   <= FrameReady | (pending & ~clr_mask);
      Overrun   <= ov_set | (Overrun & ~{2{ClrErr}});
      Timeout   <= to_evt | (Timeout & ~ClrErr);
      CoreStart <= grant_en;
      CoreAbort <= to_evt;
      ResultReq <= (state_n == S_READOUT);
      if (grant_en) ChSel <= grant;
    end
  end

endmodule

// File: tb/tb_fft_frame_scheduler.sv
// Directed testbench for fft_frame_scheduler (watchdog limit reduced to 50).
module tb_fft_frame_scheduler;

  logic       Clock;
  logic       Reset;
  logic       Enable;
  logic [1:0] FrameReady;
  logic       CoreStart;
  logic       CoreBusy;
  logic       CoreEnd;
  logic       CoreAbort;
  logic       ChSel;
  logic       ResultReq;
  logic       ResultAck;
  logic       ClrErr;
  logic [1:0] Overrun;
  logic       Timeout;

  int checks = 0;
  int errors = 0;
  int start_cnt = 0;
  int abort_cnt = 0;

  fft_frame_scheduler #(
    .wdt_limit (50),
    .bw_wdt    (16),
    .busy_wait (4)
  ) dut (
    .Clock      (Clock),
    .Reset      (Reset),
    .Enable     (Enable),
    .FrameReady (FrameReady),
    .CoreStart  (CoreStart),
    .CoreBusy   (CoreBusy),
    .CoreEnd    (CoreEnd),
    .CoreAbort  (CoreAbort),
    .ChSel      (ChSel),
    .ResultReq  (ResultReq),
    .ResultAck  (ResultAck),
    .ClrErr     (ClrErr),
    .Overrun    (Overrun),
    .Timeout    (Timeout)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic step();
    @(posedge Clock);
    #1;
    if (CoreStart === 1'b1) start_cnt++;
    if (CoreAbort === 1'b1) abort_cnt++;
  endtask

  // From the cycle after the START edge: busy after WAIT_BUSY, n quiet RUN
  // cycles, then End; returns just after the edge that entered READOUT.
  task automatic core_run(input int n);
    step();
    CoreBusy = 1'b1;
    step();
    repeat (n) step();
    CoreEnd = 1'b1;
    step();
    CoreEnd  = 1'b0;
    CoreBusy = 1'b0;
  endtask

  task automatic ack();
    ResultAck = 1'b1;
    step();
    ResultAck = 1'b0;
  endtask

  task automatic clr_err();
    ClrErr = 1'b1;
    step();
    ClrErr = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if ({CoreStart, CoreAbort, ChSel, ResultReq, Overrun, Timeout} !== 7'b0) begin
      errors++;
      $display("FAIL reset_outputs got %b want 0000000",
               {CoreStart, CoreAbort, ChSel, ResultReq, Overrun, Timeout});
    end
    step();
    step();
    Reset = 1'b0;
    step();
    checks++;
    if (CoreStart !== 1'b0) begin
      errors++; $display("FAIL reset_idle_nostart got %b want 0", CoreStart);
    end
  endtask

  task automatic test_both_pending();
    FrameReady = 2'b11;
    step();
    FrameReady = 2'b00;
    checks++;
    if (CoreStart !== 1'b0) begin errors++; $display("FAIL both_latency got %b want 0", CoreStart); end
    step();
    checks++;
    if ({CoreStart, ChSel} !== 2'b10) begin
      errors++; $display("FAIL both_first_start start/chsel got %b want 10", {CoreStart, ChSel});
    end
    core_run(10);
    checks++;
    if ({ResultReq, ChSel} !== 2'b10) begin
      errors++; $display("FAIL both_first_readout req/chsel got %b want 10", {ResultReq, ChSel});
    end
    ack();
    checks++;
    if ({ResultReq, CoreStart} !== 2'b00) begin
      errors++; $display("FAIL both_ack req/start got %b want 00", {ResultReq, CoreStart});
    end
    step();
    checks++;
    if ({CoreStart, ChSel} !== 2'b11) begin
      errors++; $display("FAIL both_second_start start/chsel got %b want 11", {CoreStart, ChSel});
    end
    core_run(10);
    checks++;
    if ({ResultReq, ChSel} !== 2'b11) begin
      errors++; $display("FAIL both_second_readout req/chsel got %b want 11", {ResultReq, ChSel});
    end
    ack();
    step();
    checks++;
    if (CoreStart !== 1'b0) begin errors++; $display("FAIL both_idle_after got %b want 0", CoreStart); end
  endtask

  task automatic test_single_frame();
    int s0;
    s0 = start_cnt;
    FrameReady = 2'b01;
    step();
    FrameReady = 2'b00;
    step();
    checks++;
    if ({CoreStart, ChSel} !== 2'b10) begin
      errors++; $display("FAIL single_start start/chsel got %b want 10", {CoreStart, ChSel});
    end
    core_run(30);
    checks++;
    if (ResultReq !== 1'b1) begin errors++; $display("FAIL single_req_rise got %b want 1", ResultReq); end
    for (int i = 0; i < 4; i++) begin
      step();
      checks++;
      if ({ResultReq, ChSel} !== 2'b10) begin
        errors++; $display("FAIL single_req_hold[%0d] req/chsel got %b want 10", i, {ResultReq, ChSel});
      end
    end
    ack();
    checks++;
    if (ResultReq !== 1'b0) begin errors++; $display("FAIL single_req_fall got %b want 0", ResultReq); end
    checks++;
    if (start_cnt - s0 !== 1) begin
      errors++; $display("FAIL single_start_count got %0d want 1", start_cnt - s0);
    end
    checks++;
    if ({Overrun, Timeout} !== 3'b000) begin
      errors++; $display("FAIL single_no_errors got %b want 000", {Overrun, Timeout});
    end
    step();
    checks++;
    if (CoreStart !== 1'b0) begin errors++; $display("FAIL single_idle got %b want 0", CoreStart); end
  endtask

  task automatic test_overrun();
    FrameReady = 2'b01;
    step();
    FrameReady = 2'b10;
    step();
    checks++;
    if ({CoreStart, ChSel} !== 2'b10) begin
      errors++; $display("FAIL ovr_start start/chsel got %b want 10", {CoreStart, ChSel});
    end
    FrameReady = 2'b00;
    CoreBusy = 1'b1;
    step();
    checks++;
    if (Overrun !== 2'b00) begin errors++; $display("FAIL ovr_first_pulse got %b want 00", Overrun); end
    FrameReady = 2'b10;
    step();
    FrameReady = 2'b00;
    checks++;
    if (Overrun !== 2'b10) begin errors++; $display("FAIL ovr_second_pulse got %b want 10", Overrun); end
    repeat (5) step();
    CoreEnd = 1'b1;
    step();
    CoreEnd = 1'b0;
    CoreBusy = 1'b0;
    checks++;
    if ({ResultReq, ChSel} !== 2'b10) begin
      errors++; $display("FAIL ovr_readout req/chsel got %b want 10", {ResultReq, ChSel});
    end
    ack();
    step();
    checks++;
    if ({CoreStart, ChSel} !== 2'b11) begin
      errors++; $display("FAIL ovr_r_start start/chsel got %b want 11", {CoreStart, ChSel});
    end
    core_run(2);
    ack();
    clr_err();
    checks++;
    if (Overrun !== 2'b00) begin errors++; $display("FAIL ovr_clear got %b want 00", Overrun); end
  endtask

  task automatic test_set_clear_enable();
    Enable = 1'b0;
    FrameReady = 2'b10;
    step();
    FrameReady = 2'b00;
    step();
    step();
    checks++;
    if (CoreStart !== 1'b0) begin errors++; $display("FAIL en_blocked got %b want 0", CoreStart); end
    Enable = 1'b1;
    FrameReady = 2'b10;
    step();
    FrameReady = 2'b00;
    checks++;
    if ({CoreStart, ChSel, Overrun} !== 4'b1100) begin
      errors++; $display("FAIL setclr_start start/chsel/ovr got %b want 1100", {CoreStart, ChSel, Overrun});
    end
    Enable = 1'b0;
    core_run(3);
    checks++;
    if ({ResultReq, ChSel} !== 2'b11) begin
      errors++; $display("FAIL en_low_no_abort req/chsel got %b want 11", {ResultReq, ChSel});
    end
    Enable = 1'b1;
    ack();
    step();
    checks++;
    if ({CoreStart, ChSel} !== 2'b11) begin
      errors++; $display("FAIL setclr_kept_pending start/chsel got %b want 11", {CoreStart, ChSel});
    end
    core_run(3);
    ack();
  endtask

  task automatic test_busy_timeout();
    int a0;
    a0 = abort_cnt;
    FrameReady = 2'b01;
    step();
    FrameReady = 2'b00;
    step();
    step();
    repeat (3) step();
    checks++;
    if ({Timeout, CoreAbort} !== 2'b00) begin
      errors++; $display("FAIL bw_early to/abort got %b want 00", {Timeout, CoreAbort});
    end
    step();
    checks++;
    if ({Timeout, CoreAbort} !== 2'b11) begin
      errors++; $display("FAIL bw_expire to/abort got %b want 11", {Timeout, CoreAbort});
    end
    step();
    checks++;
    if (CoreAbort !== 1'b0) begin errors++; $display("FAIL bw_abort_len got %b want 0", CoreAbort); end
    step();
    checks++;
    if (CoreStart !== 1'b0) begin errors++; $display("FAIL bw_pending_cleared got %b want 0", CoreStart); end
    checks++;
    if (abort_cnt - a0 !== 1) begin
      errors++; $display("FAIL bw_abort_count got %0d want 1", abort_cnt - a0);
    end
    clr_err();
    checks++;
    if (Timeout !== 1'b0) begin errors++; $display("FAIL bw_clear got %b want 0", Timeout); end
  endtask

  task automatic test_watchdog();
    int a0;
    a0 = abort_cnt;
    FrameReady = 2'b01;
    step();
    FrameReady = 2'b00;
    step();
    step();
    CoreBusy = 1'b1;
    step();
    FrameReady = 2'b10;
    step();
    FrameReady = 2'b00;
    repeat (48) step();
    checks++;
    if ({Timeout, CoreAbort, ResultReq} !== 3'b000) begin
      errors++; $display("FAIL wdt_cycle49 to/abort/req got %b want 000", {Timeout, CoreAbort, ResultReq});
    end
    ClrErr = 1'b1;
    step();
    ClrErr = 1'b0;
    CoreBusy = 1'b0;
    checks++;
    if ({Timeout, CoreAbort, ResultReq} !== 3'b110) begin
      errors++; $display("FAIL wdt_cycle50 to/abort/req got %b want 110", {Timeout, CoreAbort, ResultReq});
    end
    step();
    checks++;
    if ({CoreStart, ChSel, CoreAbort} !== 3'b110) begin
      errors++; $display("FAIL wdt_next_start start/chsel/abort got %b want 110", {CoreStart, ChSel, CoreAbort});
    end
    core_run(5);
    checks++;
    if ({ResultReq, ChSel} !== 2'b11) begin
      errors++; $display("FAIL wdt_next_readout req/chsel got %b want 11", {ResultReq, ChSel});
    end
    ack();
    checks++;
    if (abort_cnt - a0 !== 1) begin
      errors++; $display("FAIL wdt_abort_count got %0d want 1", abort_cnt - a0);
    end
    clr_err();
  endtask

  task automatic test_async_reset();
    FrameReady = 2'b10;
    step();
    FrameReady = 2'b00;
    step();
    step();
    CoreBusy = 1'b1;
    step();
    FrameReady = 2'b10;
    step();
    FrameReady = 2'b00;
    step();
    FrameReady = 2'b10;
    step();
    FrameReady = 2'b00;
    checks++;
    if ({Overrun, ChSel} !== 3'b101) begin
      errors++; $display("FAIL rst_run_pre ovr/chsel got %b want 101", {Overrun, ChSel});
    end
    #2 Reset = 1'b1;
    #1;
    checks++;
    if ({CoreStart, CoreAbort, ChSel, ResultReq, Overrun, Timeout} !== 7'b0) begin
      errors++; $display("FAIL rst_run_async got %b want 0000000",
                         {CoreStart, CoreAbort, ChSel, ResultReq, Overrun, Timeout});
    end
    #1 Reset = 1'b0;
    CoreBusy = 1'b0;
    repeat (3) step();
    checks++;
    if (CoreStart !== 1'b0) begin errors++; $display("FAIL rst_run_pending got %b want 0", CoreStart); end
    FrameReady = 2'b10;
    step();
    FrameReady = 2'b00;
    step();
    core_run(3);
    checks++;
    if ({ResultReq, ChSel} !== 2'b11) begin
      errors++; $display("FAIL rst_ro_pre req/chsel got %b want 11", {ResultReq, ChSel});
    end
    #2 Reset = 1'b1;
    #1;
    checks++;
    if ({ResultReq, ChSel} !== 2'b00) begin
      errors++; $display("FAIL rst_ro_async req/chsel got %b want 00", {ResultReq, ChSel});
    end
    #1 Reset = 1'b0;
    repeat (2) step();
    checks++;
    if ({CoreStart, ResultReq} !== 2'b00) begin
      errors++; $display("FAIL rst_ro_idle start/req got %b want 00", {CoreStart, ResultReq});
    end
    FrameReady = 2'b11;
    step();
    FrameReady = 2'b00;
    step();
    checks++;
    if ({CoreStart, ChSel} !== 2'b10) begin
      errors++; $display("FAIL rst_lastch start/chsel got %b want 10", {CoreStart, ChSel});
    end
  endtask

  initial begin
    Reset      = 1'b1;
    Enable     = 1'b1;
    FrameReady = 2'b00;
    CoreBusy   = 1'b0;
    CoreEnd    = 1'b0;
    ResultAck  = 1'b0;
    ClrErr     = 1'b0;
    test_reset();
    test_both_pending();
    test_single_frame();
    test_overrun();
    test_set_clear_enable();
    test_busy_timeout();
    test_watchdog();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
